imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// stream framing constants and small sizing helpers.
package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam int LEN_BYTES          = 2;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Capacity is kept 17 bits wide so it can be compared against a full 16-bit word count.
    function automatic logic [16:0] capacity(input int addr_width);
        return 17'(1) << addr_width;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word ends up in [7:0].
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0] idx;

    // New bytes enter at the top and shift down, so after a full word the
    // earliest byte sits in the least significant lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (byte_valid) begin
            word <= {byte_data, word[DATA_WIDTH-1:8]};
            idx  <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    assign word_valid = byte_valid && (idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: parses a length-prefixed byte stream and writes the
// assembled words into text memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err
);

    localparam logic [16:0] CAPACITY = capacity(ADDR_WIDTH);

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [15:0] len_full;
    logic        accept;
    logic        launch;
    logic        pack_valid;
    logic        word_valid;

    assign in_ready   = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign accept     = in_valid && in_ready;
    assign launch     = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign len_full   = {in_data, len[7:0]};
    assign pack_valid = accept && (state == ST_DATA);

    assign mem_we   = (state == ST_WRITE);
    assign core_rst = (state != ST_DONE);
    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERROR);

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (launch),
        .byte_data  (in_data),
        .byte_valid (pack_valid),
        .word       (mem_wdata),
        .word_valid (word_valid)
    );

    // The address only advances when another word follows, so it can never
    // wrap even for a load that fills the whole memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            word_cnt <= '0;
            mem_addr <= '0;
        end else if (launch) begin
            state    <= ST_LEN_LO;
            word_cnt <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                ST_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        if (len_full == 16'd0)
                            state <= ST_DONE;
                        else if ({1'b0, len_full} > CAPACITY)
                            state <= ST_ERROR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_valid)
                        state <= ST_WRITE;
                end
                ST_WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    if (word_cnt + 16'd1 == len) begin
                        state <= ST_DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        state    <= ST_DATA;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios with random payloads
// and gaps, checked against a stream-level model of the expected writes.
module tb_imem_loader;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst;
    logic          done;
    logic          err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]    stream_q[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            exp_cyc[$];
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int            obs_cyc[$];

    imem_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle the strobe is seen high is logged as one memory write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic reset_queues();
        exp_addr.delete();
        exp_data.delete();
        exp_cyc.delete();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    // Header is the little-endian count n, followed by 4*words random bytes.
    task automatic make_stream(input int n, input int words);
        stream_q.delete();
        stream_q.push_back(8'(n % 256));
        stream_q.push_back(8'(n / 256));
        for (int i = 0; i < 4 * words; i++)
            stream_q.push_back(8'($urandom_range(255)));
    endtask

    // Reference model: word i goes to address i and is the sum of its four
    // bytes weighted by 1, 2^8, 2^16, 2^24; oversized counts produce nothing.
    task automatic build_expect(input int max_words);
        int n;
        int limit;
        logic [DW-1:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
        if (n > (1 << AW))
            n = 0;
        limit = (n < max_words) ? n : max_words;
        for (int i = 0; i < limit; i++) begin
            w = 0;
            for (int b = 3; b >= 0; b--)
                w = w * 256 + DW'(stream_q[2 + 4 * i + b]);
            exp_addr.push_back(AW'(i));
            exp_data.push_back(w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends the first count bytes of stream_q, with optional random idle gaps
    // and an optional start pulse injected before byte start_at.
    task automatic apply_stimulus(input int count, input int gap_pct, input int start_at);
        for (int i = 0; i < count; i++) begin
            int budget;
            bit taken;
            budget = 0;
            taken  = 1'b0;
            if (i == start_at) begin
                in_valid = 1'b0;
                pulse_start();
            end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stream_q[i];
            while (!taken) begin
                if (in_ready === 1'b1) begin
                    taken = 1'b1;
                    if (i >= 2 && ((i - 2) % 4) == 3)
                        exp_cyc.push_back(cyc + 1);
                end
                @(negedge clk);
                if (!taken) begin
                    budget++;
                    if (budget > 20) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL byte_timeout: byte %0d still not accepted, in_ready=%0b required 1", i, in_ready);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic compare_writes(input string tag);
        int m;
        check_output({tag, "_count"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
            check_output($sformatf("%s_data%0d", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
            if (i < exp_cyc.size())
                check_output($sformatf("%s_lat%0d", tag, i), 64'(obs_cyc[i]), 64'(exp_cyc[i]));
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        check_output("rst_mem_we", 64'(mem_we), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_output("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_output("rst_core_rst", 64'(core_rst), 64'd1);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] scenario 1: two-word program");
        reset_queues();
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        apply_stimulus(10, 0, -1);
        repeat (2) @(negedge clk);
        build_expect(256);
        compare_writes("s1");
        if (obs_data.size() == 2) begin
            check_output("s1_lit0", 64'(obs_data[0]), 64'h0000_0013);
            check_output("s1_lit1", 64'(obs_data[1]), 64'h0010_0093);
        end
        check_output("s1_done", 64'(done), 64'd1);
        check_output("s1_core_rst", 64'(core_rst), 64'd0);

        $display("[TB] scenario 2: empty program");
        reset_queues();
        make_stream(0, 0);
        pulse_start();
        apply_stimulus(2, 0, -1);
        check_output("s2_done", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        check_output("s2_writes", 64'(obs_addr.size()), 64'd0);

        $display("[TB] scenario 3: oversized count");
        reset_queues();
        make_stream(257, 0);
        pulse_start();
        check_output("s3_done_cleared", 64'(done), 64'd0);
        apply_stimulus(2, 0, -1);
        check_output("s3_err", 64'(err), 64'd1);
        check_output("s3_core_rst", 64'(core_rst), 64'd1);
        check_output("s3_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check_output("s3_in_ready_hold", 64'(in_ready), 64'd0);
        check_output("s3_writes", 64'(obs_addr.size()), 64'd0);

        $display("[TB] scenario 4: full-capacity load with gaps");
        reset_queues();
        make_stream(256, 256);
        pulse_start();
        check_output("s4_err_cleared", 64'(err), 64'd0);
        apply_stimulus(stream_q.size(), 30, -1);
        repeat (3) @(negedge clk);
        build_expect(256);
        compare_writes("s4");
        check_output("s4_done", 64'(done), 64'd1);

        $display("[TB] scenario 5: reset mid-load");
        reset_queues();
        make_stream(3, 3);
        pulse_start();
        apply_stimulus(8, 0, -1);
        #2 rst = 1'b1;
        #1;
        check_output("s5_in_ready", 64'(in_ready), 64'd0);
        check_output("s5_mem_we", 64'(mem_we), 64'd0);
        check_output("s5_mem_addr", 64'(mem_addr), 64'd0);
        check_output("s5_mem_wdata", 64'(mem_wdata), 64'd0);
        check_output("s5_core_rst", 64'(core_rst), 64'd1);
        check_output("s5_done", 64'(done), 64'd0);
        check_output("s5_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        build_expect(1);
        compare_writes("s5a");
        reset_queues();
        make_stream(1, 1);
        pulse_start();
        apply_stimulus(6, 0, -1);
        repeat (3) @(negedge clk);
        build_expect(256);
        compare_writes("s5b");
        check_output("s5_reload_done", 64'(done), 64'd1);

        $display("[TB] scenario 6: start during data and reload from done");
        reset_queues();
        make_stream(2, 2);
        pulse_start();
        apply_stimulus(10, 0, 5);
        repeat (3) @(negedge clk);
        build_expect(256);
        compare_writes("s6");
        check_output("s6_done", 64'(done), 64'd1);
        pulse_start();
        check_output("s6_done_drop", 64'(done), 64'd0);
        check_output("s6_core_rst", 64'(core_rst), 64'd1);
        check_output("s6_in_ready", 64'(in_ready), 64'd1);
        check_output("s6_mem_addr", 64'(mem_addr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
